mem_port_arbiter: RTL and testbench

Shares one external single-port memory between the fetch stage (instruction reads) and the memory-access stage (data loads and stores) of the RockWave core. The arbiter:
- registers each granted request;
- drives the memory handshake until the memory signals completion;
- returns read data and a one-cycle acknowledge to the winning requester.

It sits between `top_fetch`/`top_memoryaccess` and the external bus, replacing their separate instruction and data memory ports.

---
 rtl/mem_port_arbiter_pkg.sv | 39 +++
 rtl/mem_arb_watchdog.sv | 39 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the fetch/data memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, fetch in flight, data in flight)
//   arb_last_e  : which requester was served most recently (round-robin memory)
//   WeLoad      : store size code meaning "read"; fetch transfers always use it
//   arb_pick()  : round-robin winner selection among the active requests
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyIf = 2'd1,
        StBusyDm = 2'd2
    } arb_state_e;

    typedef enum logic {
        LastIf = 1'b0,
        LastDm = 1'b1
    } arb_last_e;

    // Size codes follow the core's data_mem_we encoding; zero is a load.
    localparam logic [2:0] WeLoad = 3'b000;

    localparam int unsigned WdogWidth = 8;

    // Returns the busy state for the winning requester, or StIdle if none is active.
    // On a conflict the requester not served last wins.
    function automatic arb_state_e arb_pick(input logic if_act, input logic dm_act,
                                            input arb_last_e last);
        arb_state_e win;
        if (if_act && (!dm_act || (last == LastDm))) begin
            win = StBusyIf;
        end else if (dm_act) begin
            win = StBusyDm;
        end else begin
            win = StIdle;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: bus wait watchdog for mem_port_arbiter.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
//   clk, rst_n : core clock, asynchronous active-low reset
//   clear      : transfer granted this cycle; restart the count
//   busy       : a transfer is in flight this cycle
//   ready      : bus completion strobe for the in-flight transfer
//   timeout    : this busy cycle is the TIMEOUT_CYCLES-th without ready
module mem_arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic timeout
);

    // Firing when the count already holds TIMEOUT_CYCLES-1 makes the forced ack land
    // right after the TIMEOUT_CYCLES-th waiting cycle.
    localparam logic [WdogWidth-1:0] Limit = WdogWidth'(TIMEOUT_CYCLES - 1);

    logic [WdogWidth-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (busy && !ready) begin
            count_q <= count_q + WdogWidth'(1);
        end
    end

    assign timeout = busy && !ready && (count_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//   clk, rst_n                 : core clock, asynchronous active-low reset
//   if_req/if_addr             : fetch read request (level, held until if_ack)
//   if_ack/if_rdata            : fetch completion pulse and read data (held until next ack)
//   dm_req/dm_addr/dm_wdata/dm_we : data request; dm_we == 0 is a load
//   dm_ack/dm_rdata            : data completion pulse and load data (held until next ack)
//   mem_req/mem_addr/mem_wdata/mem_we : registered bus request
//   mem_rdata/mem_ready        : bus read data and completion strobe
//   mem_err                    : pulses with the ack of a timed-out transfer
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned AWIDTH         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_ack,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              dm_req,
    input  logic [AWIDTH-1:0] dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    input  logic [2:0]        dm_we,
    output logic              dm_ack,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [2:0]        mem_we,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    arb_state_e        state_q, state_d;
    arb_last_e         last_q, last_d;
    logic              mem_req_q, mem_req_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_we_q, mem_we_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              mem_err_q, mem_err_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;

    logic       if_act, dm_act;
    logic       done;
    logic       grant;
    logic       timeout;
    arb_state_e winner;

    // A requester is still seeing its own ack this cycle and has not yet dropped req.
    assign if_act = if_req && !if_ack_q;
    assign dm_act = dm_req && !dm_ack_q;
    assign winner = arb_pick(if_act, dm_act, last_q);
    assign grant  = (state_q == StIdle) && (winner != StIdle);

    // mem_req is high for every busy cycle, so ready outside a transfer never completes one.
    assign done = mem_req_q && mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (grant),
        .busy    (mem_req_q),
        .ready   (mem_ready),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d   = winner;
                    mem_req_d = 1'b1;
                    if (winner == StBusyIf) begin
                        mem_addr_d = if_addr;
                        mem_we_d   = WeLoad;
                        last_d     = LastIf;
                    end else begin
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_we_d    = dm_we;
                        last_d      = LastDm;
                    end
                end
            end
            StBusyIf: begin
                if (done || timeout) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    mem_err_d  = !done;
                    if_rdata_d = done ? mem_rdata : '0;
                end
            end
            StBusyDm: begin
                if (done || timeout) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    mem_err_d  = !done;
                    dm_rdata_d = done ? mem_rdata : '0;
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= LastDm;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            mem_err_q   <= mem_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned AWIDTH = 32;
    localparam int unsigned TO     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [AWIDTH-1:0] if_addr = '0;
    logic              if_ack;
    logic [XLEN-1:0]   if_rdata;
    logic              dm_req = 1'b0;
    logic [AWIDTH-1:0] dm_addr = '0;
    logic [XLEN-1:0]   dm_wdata = '0;
    logic [2:0]        dm_we = '0;
    logic              dm_ack;
    logic [XLEN-1:0]   dm_rdata;
    logic              mem_req;
    logic [AWIDTH-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [2:0]        mem_we;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .XLEN           (XLEN),
        .AWIDTH         (AWIDTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_we     (dm_we),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic apply_reset();
        rst_n = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_we = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [190:0] outs;
        rst_n = 1'b0;
        #1;
        outs = {mem_req, if_ack, dm_ack, mem_err, mem_addr, mem_wdata, mem_we, if_rdata, dm_rdata};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            mem_ready = ~mem_ready;
            mem_rdata = $urandom;
            @(posedge clk); #1;
            outs = {mem_req, if_ack, dm_ack, mem_err, mem_addr, mem_wdata, mem_we, if_rdata,
                    dm_rdata};
            n_checks++;
            if (outs !== '0) begin
                n_fail++; $display("FAIL idle_ready_toggle cyc %0d: got %h want 0", i, outs);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_single_fetch();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 3'b000) begin
            n_fail++;
            $display("FAIL fetch_issue: req=%b addr=%h we=%b want 1/100/000",
                     mem_req, mem_addr, mem_we);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mem_req !== 1'b1 || if_ack !== 1'b0) begin
                n_fail++; $display("FAIL fetch_wait %0d: req=%b ack=%b want 1/0", i, mem_req, if_ack);
            end
        end
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        @(posedge clk); #1;
        n_checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'h13 || mem_req !== 1'b0 || dm_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_ack: ack=%b rdata=%h req=%b dm_ack=%b want 1/13/0/0",
                     if_ack, if_rdata, mem_req, dm_ack);
        end
        if_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        n_checks++;
        if (if_ack !== 1'b0 || if_rdata !== 32'h13 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: ack=%b rdata=%h req=%b want 0/13/0", if_ack, if_rdata, mem_req);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_we = 3'b010;
        mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
        @(posedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 3'b000) begin
            n_fail++;
            $display("FAIL conflict_first_if: req=%b addr=%h we=%b want 1/40/000",
                     mem_req, mem_addr, mem_we);
        end
        @(posedge clk); #1;
        n_checks++;
        if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 32'hAAAA_0001 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_if_ack: if_ack=%b dm_ack=%b rdata=%h req=%b want 1/0/aaaa0001/0",
                     if_ack, dm_ack, if_rdata, mem_req);
        end
        if_req = 1'b0; mem_rdata = 32'hBBBB_0002;
        @(posedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF ||
            mem_we !== 3'b010 || dm_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_dm_issue: req=%b addr=%h wdata=%h we=%b want 1/2000/deadbeef/010",
                     mem_req, mem_addr, mem_wdata, mem_we);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'hBBBB_0002 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_dm_ack: ack=%b rdata=%h err=%b want 1/bbbb0002/0",
                     dm_ack, dm_rdata, mem_err);
        end
        dm_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_if;
        apply_reset();
        if_req = 1'b1; if_addr = 32'h500;
        dm_req = 1'b1; dm_addr = 32'h900; dm_wdata = 32'h1234_5678; dm_we = 3'b001;
        mem_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ((k % 2) == 1) begin
                exp_if = (((k - 1) / 2) % 2) == 0;
                if (mem_req !== 1'b1 || mem_addr !== (exp_if ? 32'h500 : 32'h900) ||
                    if_ack !== 1'b0 || dm_ack !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_grant k=%0d: req=%b addr=%h acks=%b%b want 1/%h/00",
                             k, mem_req, mem_addr, if_ack, dm_ack, exp_if ? 32'h500 : 32'h900);
                end
            end else begin
                exp_if = (((k - 2) / 2) % 2) == 0;
                if (mem_req !== 1'b0 || if_ack !== exp_if || dm_ack !== !exp_if) begin
                    n_fail++;
                    $display("FAIL b2b_ack k=%0d: req=%b if_ack=%b dm_ack=%b want 0/%b/%b",
                             k, mem_req, if_ack, dm_ack, exp_if, !exp_if);
                end
            end
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_wait_during_busy();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h700;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_addr = 32'hA00; dm_wdata = 32'h0; dm_we = 3'b000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h700 || dm_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_busy_if %0d: req=%b addr=%h want 1/700", i, mem_req, mem_addr);
            end
        end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        n_checks++;
        if (if_ack !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL wait_if_ack: ack=%b req=%b want 1/0", if_ack, mem_req);
        end
        if_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hA00 || mem_we !== 3'b000) begin
            n_fail++;
            $display("FAIL wait_dm_issue: req=%b addr=%h we=%b want 1/a00/000", mem_req, mem_addr, mem_we);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0000_7777;
        @(posedge clk); #1;
        n_checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'h7777) begin
            n_fail++; $display("FAIL wait_dm_ack: ack=%b rdata=%h want 1/7777", dm_ack, dm_rdata);
        end
        dm_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h300;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0) begin
            n_fail++; $display("FAIL mid_reset: req=%b addr=%h want 0/0", mem_req, mem_addr);
        end
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (if_ack !== 1'b0 || mem_req !== 1'b0 || if_rdata !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_noack %0d: ack=%b req=%b rdata=%h want 0/0/0",
                         i, if_ack, mem_req, if_rdata);
            end
        end
        mem_ready = 1'b0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        dm_req = 1'b1; dm_addr = 32'h40; dm_we = 3'b000; mem_ready = 1'b1; mem_rdata = 32'h55;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'h55) begin
            n_fail++; $display("FAIL to_preload: ack=%b rdata=%h want 1/55", dm_ack, dm_rdata);
        end
        dm_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_addr = 32'h80;
        @(posedge clk); #1;
        for (int i = 0; i < int'(TO) - 1; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (dm_ack !== 1'b0 || mem_req !== 1'b1 || mem_err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait %0d: ack=%b req=%b err=%b want 0/1/0", i, dm_ack, mem_req, mem_err);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (dm_ack !== 1'b1 || mem_err !== 1'b1 || dm_rdata !== '0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fire: ack=%b err=%b rdata=%h req=%b want 1/1/0/0",
                     dm_ack, mem_err, dm_rdata, mem_req);
        end
        dm_req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (mem_err !== 1'b0 || dm_ack !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: err=%b ack=%b want 0/0", mem_err, dm_ack);
        end
    endtask
`endif

    // Random traffic against a transaction-level model of the arbitration rules.
    task automatic test_random();
        int          m_owner;      // 0 none, 1 fetch, 2 data
        bit          m_if_ack, m_dm_ack, m_last_dm, old_if_ack, old_dm_ack, a_if, a_dm;
        logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
        logic [2:0]  m_we;
        bit          s_if, s_dm, s_ready;
        logic [31:0] s_ifa, s_dma, s_wd, s_rd;
        logic [2:0]  s_we;
        bit          if_late, dm_late, if_drop, dm_drop;
        int          busy_cnt;

        apply_reset();
        m_owner = 0; m_if_ack = 0; m_dm_ack = 0; m_last_dm = 1;
        m_addr = '0; m_wdata = '0; m_we = '0; m_if_rdata = '0; m_dm_rdata = '0;
        if_drop = 0; dm_drop = 0; busy_cnt = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            s_if = if_req; s_dm = dm_req; s_ifa = if_addr; s_dma = dm_addr;
            s_wd = dm_wdata; s_we = dm_we; s_ready = mem_ready; s_rd = mem_rdata;
            @(posedge clk); #1;

            old_if_ack = m_if_ack; old_dm_ack = m_dm_ack;
            m_if_ack = 0; m_dm_ack = 0;
            if (m_owner == 1) begin
                if (s_ready) begin m_if_ack = 1; m_if_rdata = s_rd; m_owner = 0; end
            end else if (m_owner == 2) begin
                if (s_ready) begin m_dm_ack = 1; m_dm_rdata = s_rd; m_owner = 0; end
            end else begin
                a_if = s_if && !old_if_ack;
                a_dm = s_dm && !old_dm_ack;
                if (a_if && (!a_dm || m_last_dm)) begin
                    m_owner = 1; m_addr = s_ifa; m_we = 3'b000; m_last_dm = 0;
                end else if (a_dm) begin
                    m_owner = 2; m_addr = s_dma; m_wdata = s_wd; m_we = s_we; m_last_dm = 1;
                end
            end

            n_checks++;
            if (mem_req !== (m_owner != 0) || if_ack !== m_if_ack || dm_ack !== m_dm_ack ||
                mem_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_ctrl cyc %0d: req/ifack/dmack/err=%b%b%b%b want %b%b%b0", cyc,
                         mem_req, if_ack, dm_ack, mem_err, m_owner != 0, m_if_ack, m_dm_ack);
            end
            n_checks++;
            if (mem_addr !== m_addr || mem_we !== m_we ||
                (m_owner == 2 && mem_wdata !== m_wdata)) begin
                n_fail++;
                $display("FAIL rnd_bus cyc %0d: addr=%h we=%b wdata=%h want %h/%b/%h", cyc,
                         mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
            end
            n_checks++;
            if (if_rdata !== m_if_rdata || dm_rdata !== m_dm_rdata) begin
                n_fail++;
                $display("FAIL rnd_rdata cyc %0d: if=%h dm=%h want %h/%h", cyc,
                         if_rdata, dm_rdata, m_if_rdata, m_dm_rdata);
            end

            // Fetch requester: sometimes drops req one cycle late after its ack.
            if (if_drop) begin
                if_req = 1'b0; if_drop = 0;
            end else if (if_req) begin
                if (if_ack) begin
                    if_late = ($urandom_range(0, 1) == 1);
                    if (if_late) if_drop = 1; else if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (dm_drop) begin
                dm_req = 1'b0; dm_drop = 0;
            end else if (dm_req) begin
                if (dm_ack) begin
                    dm_late = ($urandom_range(0, 1) == 1);
                    if (dm_late) dm_drop = 1; else dm_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_addr = $urandom; dm_wdata = $urandom;
                dm_we = 3'($urandom_range(0, 4));
            end

            // Memory: random waits (bounded under the watchdog limit), noise while idle.
            busy_cnt  = mem_req ? busy_cnt + 1 : 0;
            mem_ready = mem_req ? ((busy_cnt >= 3) || ($urandom_range(0, 1) == 1))
                                : ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_conflict();
        test_back_to_back();
        test_wait_during_busy();
        test_reset_mid_transfer();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
